fifo_pkt_reader: RTL and testbench

Drain-side companion to the team's register FIFO. It pops words from a first-word-fall-through FIFO, frames them into packets from a length header, and presents them on a valid/ready stream with start/end markers. It sits between a switch-port ingress FIFO and the shared-cache write path, and decouples FIFO timing from downstream backpressure through a 2-entry output buffer.

---
 rtl/fifo_pkt_reader_pkg.sv | 26 ++
 rtl/fifo_pkt_reader_if.sv | 45 ++++
 rtl/fifo_pkt_reader_skid_buf.sv | 57 +++++
 rtl/fifo_pkt_reader.sv | 124 ++++++++++++
 tb/tb_fifo_pkt_reader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types for the packet reader: FSM states, output buffer entry, default widths.
// Latency: n/a (types only). Backpressure: n/a.
package fifo_pkt_pkg;

   localparam int PKT_DATA_W = 8;
   localparam int PKT_LEN_W  = 4;
   localparam int PKT_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD
   } rd_state_t;

   typedef struct packed {
      logic [PKT_DATA_W-1:0] data;
      logic                  sop;
      logic                  eop;
      logic                  err;
   } buf_entry_t;

   function automatic logic [PKT_CNT_W-1:0] cnt_inc(input logic [PKT_CNT_W-1:0] cnt);
      return cnt + 1'b1;
   endfunction

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FIFO drain side plus framed output stream of the packet reader.
// Latency: n/a (wires only). Backpressure: out_ready towards the reader, fifo_empty from the FIFO.
interface fifo_pkt_reader_if #(
   parameter int DATA_WIDTH = fifo_pkt_pkg::PKT_DATA_W
) ();
   import fifo_pkt_pkg::*;

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_sop;
   logic                  out_eop;
   logic                  out_err;
   logic [PKT_CNT_W-1:0]  pkt_count;

   modport master (
      input  fifo_empty,
      input  fifo_rd_data,
      output fifo_rd_en,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_sop,
      output out_eop,
      output out_err,
      output pkt_count
   );

   modport slave (
      output fifo_empty,
      output fifo_rd_data,
      input  fifo_rd_en,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_sop,
      input  out_eop,
      input  out_err,
      input  pkt_count
   );

endinterface

// File: rtl/fifo_pkt_reader_skid_buf.sv
// Two-entry in-order valid/ready buffer; a write appears at the head one cycle later.
// Backpressure: head held while rd_rdy=0; writer must only push while occupancy < 2.
module pkt_skid_buf
   import fifo_pkt_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_vld,
   input  buf_entry_t wr_dat,
   output logic       rd_vld,
   input  logic       rd_rdy,
   output buf_entry_t rd_dat,
   output logic [1:0] occupancy
);

   logic [1:0] occ_q;
   buf_entry_t head_q;
   buf_entry_t tail_q;
   logic       rd_fire;

   assign rd_fire = (occ_q != 2'd0) & rd_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case ({wr_vld, rd_fire})
            2'b10: begin
               if (occ_q == 2'd0) head_q <= wr_dat;
               else               tail_q <= wr_dat;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               // Simultaneous push and pop: occupancy holds, order preserved.
               if (occ_q == 2'd2) begin
                  head_q <= tail_q;
                  tail_q <= wr_dat;
               end else begin
                  head_q <= wr_dat;
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_vld    = (occ_q != 2'd0);
   assign rd_dat    = head_q;
   assign occupancy = occ_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Frames FWFT FIFO words into sop/eop packets from a length header; pop-to-output latency 1 cycle.
// Backpressure: pops stop while the 2-entry output buffer is full. FIFO_PKT_READER_TIMEOUT_EN adds starvation truncation.
module fifo_pkt_reader
   import fifo_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = PKT_DATA_W,
   parameter int LEN_WIDTH  = PKT_LEN_W,
   parameter int TIMEOUT    = 64
) (
   input  logic                clk,
   input  logic                rst,
   fifo_pkt_reader_if.master   bus
);

   rd_state_t             state_q, state_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [LEN_WIDTH-1:0]  hdr_len;
   logic [1:0]            occ;
   logic                  space;
   logic                  pop;
   logic                  push;
   buf_entry_t            push_dat;
   buf_entry_t            head;
   logic                  head_vld;
   logic [PKT_CNT_W-1:0]  cnt_q;
   logic                  to_fire;

   assign space   = (occ < 2'd2);
   assign hdr_len = bus.fifo_rd_data[LEN_WIDTH-1:0];

`ifdef FIFO_PKT_READER_TIMEOUT_EN
   logic [15:0] starve_q;

   // Truncation competes with popping: once fired it owns the buffer write slot.
   assign to_fire = (state_q == PAYLOAD) && (starve_q >= 16'(TIMEOUT)) && space;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 16'd0;
      end else if ((state_q != PAYLOAD) || pop) begin
         starve_q <= 16'd0;
      end else if (bus.fifo_empty && (starve_q != 16'hFFFF)) begin
         starve_q <= starve_q + 16'd1;
      end
   end
`else
   assign to_fire = 1'b0;
`endif

   assign pop            = ~bus.fifo_empty & space & ~rst & ~to_fire;
   assign bus.fifo_rd_en = pop;

   // IDLE doubles as the header state so a header can pop right behind an eop pop.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      push     = 1'b0;
      push_dat = '0;
      case (state_q)
         IDLE, HDR: begin
            if (pop) begin
               push         = 1'b1;
               push_dat.data = bus.fifo_rd_data;
               push_dat.sop  = 1'b1;
               if (hdr_len == '0) begin
                  push_dat.eop = 1'b1;
                  state_d      = IDLE;
               end else begin
                  rem_d   = hdr_len;
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (pop) begin
               push          = 1'b1;
               push_dat.data = bus.fifo_rd_data;
               rem_d         = rem_q - 1'b1;
               if (rem_q == LEN_WIDTH'(1)) begin
                  push_dat.eop = 1'b1;
                  state_d      = IDLE;
               end
            end else if (to_fire) begin
               push         = 1'b1;
               push_dat.eop = 1'b1;
               push_dat.err = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         if (head_vld && bus.out_ready && head.eop) cnt_q <= cnt_inc(cnt_q);
      end
   end

   pkt_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .wr_vld    (push),
      .wr_dat    (push_dat),
      .rd_vld    (head_vld),
      .rd_rdy    (bus.out_ready),
      .rd_dat    (head),
      .occupancy (occ)
   );

   assign bus.out_valid = head_vld;
   assign bus.out_data  = head.data;
   assign bus.out_sop   = head.sop;
   assign bus.out_eop   = head.eop;
   assign bus.out_err   = head.err;
   assign bus.pkt_count = cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: cycle table, backpressure, timeout, async reset, counter wrap.
module tb_fifo_pkt_reader;
   import fifo_pkt_pkg::*;

   logic clk;
   logic rst;

   fifo_pkt_reader_if bus ();

   fifo_pkt_reader #(
      .DATA_WIDTH (8),
      .LEN_WIDTH  (4),
      .TIMEOUT    (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   int tests      = 0;
   int fails      = 0;
   int proto_err  = 0;
   int cyc        = 0;
   int occ_m      = 0;
   int ready_mode = 0;

   logic [7:0] fq[$];

   typedef struct {
      logic [7:0] d;
      bit         sop;
      bit         eop;
      bit         err;
   } exp_t;
   exp_t eq[$];

   typedef struct {
      bit         emp;
      logic [7:0] din;
      bit         rdy;
      bit         e_rd;
      bit         e_vld;
      logic [7:0] e_dat;
      bit         e_sop;
      bit         e_eop;
      logic [15:0] e_cnt;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic exp_push(input logic [7:0] d, input bit s, input bit e, input bit r);
      exp_t x;
      x.d = d; x.sop = s; x.eop = e; x.err = r;
      eq.push_back(x);
   endtask

   task automatic drive();
      bus.fifo_empty   = (fq.size() == 0);
      bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = ((cyc % 3) == 0);
         default: bus.out_ready = 1'b0;
      endcase
   endtask

   // One cycle: sample just before the rising edge, advance the FIFO model at the falling edge.
   task automatic tick();
      logic rd, hs;
      exp_t x;
      #4;
      rd = bus.fifo_rd_en;
      hs = bus.out_valid & bus.out_ready;
      if (rd !== (!bus.fifo_empty && occ_m < 2)) proto_err++;
      if (bus.out_valid !== (occ_m != 0)) proto_err++;
      if (hs) begin
         if (eq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_word: got data %h sop %0b eop %0b err %0b, expected no word",
                     bus.out_data, bus.out_sop, bus.out_eop, bus.out_err);
         end else begin
            x = eq.pop_front();
            check("word", {21'h0, bus.out_data, bus.out_sop, bus.out_eop, bus.out_err},
                          {21'h0, x.d, x.sop, x.eop, x.err});
         end
      end
      @(negedge clk);
      if (rd) void'(fq.pop_front());
      occ_m = occ_m + int'(rd) - int'(hs);
      cyc++;
      drive();
   endtask

   task automatic run(input int max, input int idle, input string name);
      int n = 0;
      while ((eq.size() != 0 || fq.size() != 0) && n < max) begin
         tick();
         n++;
      end
      check({name, "_done"}, 32'(n < max), 32'd1);
      repeat (idle) tick();
      check({name, "_proto"}, proto_err, 0);
      proto_err = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fq.delete();
      eq.delete();
      occ_m      = 0;
      cyc        = 0;
      ready_mode = 0;
      drive();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [10:0] af, ef;

      tbl[0] = '{1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 16'd0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 16'd0};
      tbl[5] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 16'd1};
      tbl[6] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 16'd2};
      tbl[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 16'd2};
      tbl[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd3};

      // Reset values, with a non-empty FIFO to show the pop is held off.
      rst              = 1'b1;
      bus.fifo_empty   = 1'b0;
      bus.fifo_rd_data = 8'h03;
      bus.out_ready    = 1'b1;
      #4;
      check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data",  32'(bus.out_data), 32'd0);
      check("rst_flags", {29'h0, bus.out_sop, bus.out_eop, bus.out_err}, 32'd0);
      check("rst_count", 32'(bus.pkt_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Cycle table: 3-payload packet, header-only packet, 1-payload packet back to back.
      for (int i = 0; i < 9; i++) begin
         bus.fifo_empty   = tbl[i].emp;
         bus.fifo_rd_data = tbl[i].din;
         bus.out_ready    = tbl[i].rdy;
         #4;
         af = tbl[i].e_vld ? {bus.out_data, bus.out_sop, bus.out_eop, bus.out_err} : 11'h0;
         ef = tbl[i].e_vld ? {tbl[i].e_dat, tbl[i].e_sop, tbl[i].e_eop, 1'b0} : 11'h0;
         check($sformatf("vec%0d", i),
               {3'h0, bus.fifo_rd_en, bus.out_valid, bus.pkt_count, af},
               {3'h0, tbl[i].e_rd, tbl[i].e_vld, tbl[i].e_cnt, ef});
         @(negedge clk);
      end

      // Two 2-payload packets under a 1,0,0 ready pattern.
      do_reset();
      fq.push_back(8'h02); fq.push_back(8'hB1); fq.push_back(8'hB2);
      fq.push_back(8'h12); fq.push_back(8'hC1); fq.push_back(8'hC2);
      exp_push(8'h02, 1, 0, 0); exp_push(8'hB1, 0, 0, 0); exp_push(8'hB2, 0, 1, 0);
      exp_push(8'h12, 1, 0, 0); exp_push(8'hC1, 0, 0, 0); exp_push(8'hC2, 0, 1, 0);
      ready_mode = 1;
      drive();
      run(100, 4, "bp");
      check("bp_count", 32'(bus.pkt_count), 32'd2);

      // Header promises 5 payloads, only 2 arrive.
      do_reset();
      fq.push_back(8'h05); fq.push_back(8'hD1); fq.push_back(8'hD2);
      exp_push(8'h05, 1, 0, 0); exp_push(8'hD1, 0, 0, 0); exp_push(8'hD2, 0, 0, 0);
`ifdef FIFO_PKT_READER_TIMEOUT_EN
      exp_push(8'h00, 0, 1, 1);
`endif
      drive();
      run(300, 80, "to");
`ifdef FIFO_PKT_READER_TIMEOUT_EN
      check("to_count", 32'(bus.pkt_count), 32'd1);
`else
      check("to_count", 32'(bus.pkt_count), 32'd0);
`endif

      // Asynchronous reset with two entries buffered mid-payload.
      do_reset();
      fq.push_back(8'h00); fq.push_back(8'h04); fq.push_back(8'hE1);
      fq.push_back(8'h20); fq.push_back(8'h31); fq.push_back(8'h44);
      exp_push(8'h00, 1, 1, 0);
      drive();
      tick();
      ready_mode = 2;
      tick();
      tick();
      tick();
      check("pre_rst_count", 32'(bus.pkt_count), 32'd1);
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      check("pre_rst_proto", proto_err, 0);
      proto_err = 0;
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_count", 32'(bus.pkt_count), 32'd0);
      check("arst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      occ_m = 0;
      exp_push(8'h20, 1, 1, 0); exp_push(8'h31, 1, 0, 0); exp_push(8'h44, 0, 1, 0);
      ready_mode = 0;
      drive();
      run(50, 4, "rst");
      check("rst_seq_count", 32'(bus.pkt_count), 32'd2);

      // Counter wrap with header-only packets.
      do_reset();
      bus.out_ready    = 1'b1;
      bus.fifo_rd_data = 8'h00;
      bus.fifo_empty   = 1'b0;
      repeat (65535) @(negedge clk);
      bus.fifo_empty = 1'b1;
      repeat (3) @(negedge clk);
      #4;
      check("wrap_ffff", 32'(bus.pkt_count), 32'h0000FFFF);
      @(negedge clk);
      bus.fifo_empty = 1'b0;
      @(negedge clk);
      bus.fifo_empty = 1'b1;
      repeat (3) @(negedge clk);
      #4;
      check("wrap_zero", 32'(bus.pkt_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
